// File: rtl/i2s_clock_controller_if.sv
// i2s_clock_controller_if: run request and I2S clock/status outputs of the controller
interface i2s_clock_controller_if;
  logic       enable_i;
  logic       bclk_o;
  logic       lrclk_o;
  logic       frame_start_o;
  logic       rx_en_o;
  logic       busy_o;
  logic [1:0] state_o;
  modport master(input enable_i, output bclk_o, lrclk_o, frame_start_o, rx_en_o, busy_o, state_o);
  modport slave(output enable_i, input bclk_o, lrclk_o, frame_start_o, rx_en_o, busy_o, state_o);
endinterface

// File: rtl/i2s_clock_controller.sv
// i2s_clock_controller: generates I2S bclk/lrclk with ADC settle, run and frame-aligned stop
module i2s_clock_controller #(
  parameter int BCLK_DIV      = 8,
  parameter int SLOT_WIDTH    = 32,
  parameter int SETTLE_FRAMES = 4
) (
  input logic                    clk_i,
  input logic                    rst_n_i,
  i2s_clock_controller_if.master bus
);
  localparam int BW = $clog2(2 * SLOT_WIDTH);
  localparam int FW = SETTLE_FRAMES > 0 ? $clog2(SETTLE_FRAMES + 1) : 1;
  localparam logic [7:0]    DIV_LAST = 8'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_WIDTH - 1);
  localparam logic [BW-1:0] SLOT     = BW'(SLOT_WIDTH);
  localparam logic [FW-1:0] SF_MAX   = FW'(SETTLE_FRAMES);
  localparam logic [FW-1:0] SF_LAST  = FW'(SETTLE_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, STOP} state_t;

  state_t        state, next;
  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [7:0]    div_cnt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [FW-1:0] frame_cnt;
  logic          bclk, lrclk, frame_start, rx_en, busy;
  logic          dwrap, fall, fwrap, clr;

  assign rst_n   = rst_sync[1];
  assign dwrap   = div_cnt == DIV_LAST;
  assign fall    = dwrap && bclk;
  assign fwrap   = fall && bit_cnt == BIT_LAST;
  assign bit_nxt = fwrap ? '0 : bit_cnt + BW'(1);
  assign clr     = state == IDLE || next == IDLE;

  assign bus.bclk_o        = bclk;
  assign bus.lrclk_o       = lrclk;
  assign bus.frame_start_o = frame_start;
  assign bus.rx_en_o       = rx_en;
  assign bus.busy_o        = busy;
  assign bus.state_o       = state;

  // reset asserts immediately, releases two clk_i edges later
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};

  // state register
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;

  // next state: settle counts frames, stop waits for the frame wrap
  always_comb begin
    next = state;
    unique case (state)
      IDLE:   next = bus.enable_i ? (SETTLE_FRAMES == 0 ? RUN : SETTLE) : IDLE;
      SETTLE: next = !bus.enable_i ? IDLE : (fwrap && frame_cnt == SF_LAST) ? RUN : SETTLE;
      RUN:    next = bus.enable_i ? RUN : STOP;
      STOP:   next = fwrap ? IDLE : STOP;
    endcase
  end

  // clock divider, bit/frame counters and registered outputs; IDLE holds everything at zero
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      frame_cnt   <= '0;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      frame_start <= 1'b0;
      rx_en       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy        <= next != IDLE;
      frame_start <= fwrap && !clr;
      rx_en       <= (state == RUN || state == STOP) ? next != IDLE : state == IDLE && next == RUN;
      if (clr) begin
        div_cnt   <= '0;
        bit_cnt   <= '0;
        frame_cnt <= '0;
        bclk      <= 1'b0;
        lrclk     <= 1'b0;
      end else begin
        div_cnt <= dwrap ? '0 : div_cnt + 8'd1;
        bclk    <= bclk ^ dwrap;
        if (fall) begin
          bit_cnt <= bit_nxt;
          lrclk   <= bit_nxt >= SLOT;
        end
        if (state == SETTLE && fwrap && frame_cnt != SF_MAX) frame_cnt <= frame_cnt + FW'(1);
      end
    end
endmodule

// File: tb/tb_i2s_clock_controller.sv
// tb_i2s_clock_controller: scenario bench comparing three controller configurations to a timeline model
module tb_i2s_clock_controller;
  localparam int NONE = 1 << 30;
  localparam int FA = 256;
  localparam int FB = 128;
  localparam int FC = 36;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [6:0] oa, ob, oc;

  i2s_clock_controller_if ia();
  i2s_clock_controller_if ib();
  i2s_clock_controller_if ic();

  i2s_clock_controller #(.BCLK_DIV(2), .SLOT_WIDTH(32), .SETTLE_FRAMES(2)) dut_a (.clk_i(clk), .rst_n_i(rst_n), .bus(ia));
  i2s_clock_controller #(.BCLK_DIV(1), .SLOT_WIDTH(32), .SETTLE_FRAMES(0)) dut_b (.clk_i(clk), .rst_n_i(rst_n), .bus(ib));
  i2s_clock_controller #(.BCLK_DIV(3), .SLOT_WIDTH(3),  .SETTLE_FRAMES(3)) dut_c (.clk_i(clk), .rst_n_i(rst_n), .bus(ic));

  assign oa = {ia.bclk_o, ia.lrclk_o, ia.frame_start_o, ia.rx_en_o, ia.busy_o, ia.state_o};
  assign ob = {ib.bclk_o, ib.lrclk_o, ib.frame_start_o, ib.rx_en_o, ib.busy_o, ib.state_o};
  assign oc = {ic.bclk_o, ic.lrclk_o, ic.frame_start_o, ic.rx_en_o, ic.busy_o, ic.state_o};

  always #5 clk = ~clk;

  // Expected {bclk, lrclk, frame_start, rx_en, busy, state} t cycles after the enable was taken.
  // ts: cycle at which the dropped enable takes effect; rs: cycle at which a fresh run restarts.
  function automatic logic [6:0] model(int t, int d, int sw, int sf, int ts, int rs);
    int f, ps, te, b;
    logic [1:0] st;
    if (rs > 0 && t >= rs) begin
      t  = t - rs;
      ts = NONE;
    end
    f  = 4 * d * sw;
    ps = sf * f;
    te = (ts / f + 1) * f;
    if (t < 0 || (ts <= ps && t >= ts) || (ts > ps && t >= te)) return '0;
    b  = (t / (2 * d)) % (2 * sw);
    st = t >= ts ? 2'd3 : t < ps ? 2'd1 : 2'd2;
    return {1'((t / d) % 2), b >= sw, t > 0 && t % f == 0, sf == 0 || t > ps, 1'b1, st};
  endfunction

  task automatic test_reset;
    logic [6:0] ea, eb, ec;
    ia.enable_i = 1'b1;
    ib.enable_i = 1'b1;
    ic.enable_i = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({oa, ob, oc} !== '0) begin
      errors++;
      $display("FAIL reset_hold got %b %b %b want all zero", oa, ob, oc);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({oa, ob, oc} !== '0) begin
        errors++;
        $display("FAIL reset_release edge %0d got %b %b %b want all zero", e, oa, ob, oc);
      end
    end
    @(posedge clk);
    #1;
    ea = model(0, 2, 32, 2, NONE, 0);
    eb = model(0, 1, 32, 0, NONE, 0);
    ec = model(0, 3, 3, 3, NONE, 0);
    checks++;
    if ({oa, ob, oc} !== {ea, eb, ec}) begin
      errors++;
      $display("FAIL first_entry got %b %b %b want %b %b %b", oa, ob, oc, ea, eb, ec);
    end
    ia.enable_i = 1'b0;
    ib.enable_i = 1'b0;
    ic.enable_i = 1'b0;
    repeat (FB + 2) @(posedge clk);
    #1;
    checks++;
    if ({oa, ob, oc} !== '0) begin
      errors++;
      $display("FAIL back_to_idle got %b %b %b want all zero", oa, ob, oc);
    end
  endtask

  task automatic test_settle_run;
    int ts, fs_cnt, fs2, rx_rise, lr_bad, lr_hi;
    logic [6:0] exp;
    logic pb, pl;
    ts = 700; fs_cnt = 0; fs2 = -1; rx_rise = -1; lr_bad = 0; lr_hi = 0; pb = 1'b0; pl = 1'b0;
    ia.enable_i = 1'b1;
    for (int t = 0; t <= 3 * FA + 2; t++) begin
      @(posedge clk);
      #1;
      exp = model(t, 2, 32, 2, ts, 0);
      checks++;
      if (oa !== exp) begin
        errors++;
        $display("FAIL settle_run t=%0d got %b want %b", t, oa, exp);
      end
      if (ia.frame_start_o) begin
        fs_cnt++;
        if (fs_cnt == 2) fs2 = t;
      end
      if (ia.rx_en_o && rx_rise < 0) rx_rise = t;
      if (ia.lrclk_o != pl && !(pb && !ia.bclk_o)) lr_bad++;
      if (t >= FA && t < 2 * FA && ia.lrclk_o) lr_hi++;
      pb = ia.bclk_o;
      pl = ia.lrclk_o;
      if (t == ts - 1) ia.enable_i = 1'b0;
    end
    checks++;
    if (fs2 !== 2 * FA) begin
      errors++;
      $display("FAIL second_frame_start got t=%0d want t=%0d", fs2, 2 * FA);
    end
    checks++;
    if (rx_rise !== fs2 + 1) begin
      errors++;
      $display("FAIL rx_en_rise got t=%0d want t=%0d", rx_rise, fs2 + 1);
    end
    checks++;
    if (lr_bad !== 0) begin
      errors++;
      $display("FAIL lrclk_off_fall got %0d toggles want 0", lr_bad);
    end
    checks++;
    if (lr_hi !== FA / 2) begin
      errors++;
      $display("FAIL lrclk_high_cycles got %0d want %0d", lr_hi, FA / 2);
    end
  endtask

  task automatic test_stop;
    int ts, te, rises;
    logic [6:0] exp;
    logic pb;
    ts = 2 * FA + 43; te = 3 * FA; rises = 0; pb = 1'b0;
    ia.enable_i = 1'b1;
    for (int t = 0; t <= te + 4; t++) begin
      @(posedge clk);
      #1;
      exp = model(t, 2, 32, 2, ts, te + 1);
      checks++;
      if (oa !== exp) begin
        errors++;
        $display("FAIL stop t=%0d got %b want %b", t, oa, exp);
      end
      if (t > ts && t < te && ia.bclk_o && !pb) rises++;
      pb = ia.bclk_o;
      if (t == ts - 1) ia.enable_i = 1'b0;
      if (t == ts + 5) ia.enable_i = 1'b1;
    end
    checks++;
    if (rises !== 53) begin
      errors++;
      $display("FAIL stop_bclk_periods got %0d want 53", rises);
    end
    ia.enable_i = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (oa !== '0) begin
      errors++;
      $display("FAIL stop_restart_abort got %b want 0", oa);
    end
  endtask

  task automatic test_abort;
    int ts, rx_seen;
    logic [6:0] exp;
    ts = $urandom_range(FA + 1, 2 * FA);
    rx_seen = 0;
    ia.enable_i = 1'b1;
    for (int t = 0; t <= ts + 2; t++) begin
      @(posedge clk);
      #1;
      exp = model(t, 2, 32, 2, ts, 0);
      checks++;
      if (oa !== exp) begin
        errors++;
        $display("FAIL abort t=%0d ts=%0d got %b want %b", t, ts, oa, exp);
      end
      if (ia.rx_en_o) rx_seen++;
      if (t == ts - 1) ia.enable_i = 1'b0;
    end
    checks++;
    if (rx_seen !== 0) begin
      errors++;
      $display("FAIL abort_rx_en got %0d cycles want 0", rx_seen);
    end
    ts = 2 * FA + 4;
    ia.enable_i = 1'b1;
    for (int t = 0; t <= 3 * FA + 2; t++) begin
      @(posedge clk);
      #1;
      exp = model(t, 2, 32, 2, ts, 0);
      checks++;
      if (oa !== exp) begin
        errors++;
        $display("FAIL resettle t=%0d got %b want %b", t, oa, exp);
      end
      if (t == ts - 1) ia.enable_i = 1'b0;
    end
  endtask

  task automatic test_async_reset;
    int dly;
    logic [6:0] exp;
    ia.enable_i = 1'b1;
    for (int t = 0; t <= 2 * FA + 88; t++) begin
      @(posedge clk);
      #1;
      exp = model(t, 2, 32, 2, NONE, 0);
      checks++;
      if (oa !== exp) begin
        errors++;
        $display("FAIL pre_reset_run t=%0d got %b want %b", t, oa, exp);
      end
    end
    dly = $urandom_range(1, 7);
    #(dly);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({oa, ob, oc} !== '0) begin
      errors++;
      $display("FAIL async_reset got %b %b %b want all zero", oa, ob, oc);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (oa !== '0) begin
        errors++;
        $display("FAIL async_release edge %0d got %b want 0", e, oa);
      end
    end
    for (int t = 0; t <= 302; t++) begin
      @(posedge clk);
      #1;
      exp = model(t, 2, 32, 2, 300, 0);
      checks++;
      if (oa !== exp) begin
        errors++;
        $display("FAIL post_reset_settle t=%0d got %b want %b", t, oa, exp);
      end
      if (t == 299) ia.enable_i = 1'b0;
    end
  endtask

  task automatic test_no_settle;
    int ts, te;
    logic [6:0] exp;
    for (int i = 0; i < 2; i++) begin
      ts = $urandom_range(1, 3 * FB);
      te = (ts / FB + 1) * FB;
      ib.enable_i = 1'b1;
      for (int t = 0; t <= te + 2; t++) begin
        @(posedge clk);
        #1;
        exp = model(t, 1, 32, 0, ts, 0);
        checks++;
        if (ob !== exp) begin
          errors++;
          $display("FAIL no_settle t=%0d ts=%0d got %b want %b", t, ts, ob, exp);
        end
        if (t == ts - 1) ib.enable_i = 1'b0;
      end
    end
  endtask

  task automatic test_random;
    int ts, n, gap;
    logic [6:0] exp;
    for (int i = 0; i < 8; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      ts = $urandom_range(1, 3 * FC + 2 * FC);
      n  = ts <= 3 * FC ? ts + 2 : (ts / FC + 1) * FC + 2;
      ic.enable_i = 1'b1;
      for (int t = 0; t <= n; t++) begin
        @(posedge clk);
        #1;
        exp = model(t, 3, 3, 3, ts, 0);
        checks++;
        if (oc !== exp) begin
          errors++;
          $display("FAIL random it=%0d t=%0d ts=%0d got %b want %b", i, t, ts, oc, exp);
        end
        if (t == ts - 1) ic.enable_i = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_settle_run();
    test_stop();
    test_abort();
    test_async_reset();
    test_no_settle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
